// File: rtl/dm_pkg.sv
// dm_pkg: shared width/sign codes, exception codes and FSM state type
// for the dm_pipe data memory.
package dm_pkg;

  // Width/sign codes carried in req_op[3:1]
  localparam logic [2:0] W_WORD  = 3'd0;
  localparam logic [2:0] W_BYTE  = 3'd1;
  localparam logic [2:0] W_HALF  = 3'd2;
  localparam logic [2:0] W_BYTEU = 3'd3;
  localparam logic [2:0] W_HALFU = 3'd4;

  // Response exception codes
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } dm_state_e;

  // Codes 5..7 are undefined; unsigned widths make no sense for stores.
  function automatic logic is_illegal(input logic [2:0] width, input logic wr);
    return (width > W_HALFU) || (wr && ((width == W_BYTEU) || (width == W_HALFU)));
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt: combinational lane handling for dm_pipe.
// Store side: replicates store data across lanes and produces a byte write mask.
// Load side: extracts the addressed byte/half and sign- or zero-extends it.
// Half accesses use lane[1] only and word accesses ignore lane entirely.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane select, store merge and load extension
  always_comb begin
    st_mask  = '0;
    st_lanes = '0;
    ld_data  = '0;
    ld_byte  = 8'(rword >> {lane, 3'b000});
    ld_half  = lane[1] ? rword[31:16] : rword[15:0];
    case (width)
      W_WORD: begin
        st_mask  = 4'b1111;
        st_lanes = wdata;
        ld_data  = rword;
      end
      W_BYTE: begin
        st_mask  = 4'b0001 << lane;
        st_lanes = {4{wdata[7:0]}};
        ld_data  = {{24{ld_byte[7]}}, ld_byte};
      end
      W_HALF: begin
        st_mask  = lane[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{wdata[15:0]}};
        ld_data  = {{16{ld_half[15]}}, ld_half};
      end
      W_BYTEU: ld_data = {24'h0, ld_byte};
      W_HALFU: ld_data = {16'h0, ld_half};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dm_pipe.sv
// dm_pipe: pipelined data memory for the MEM stage.
// Word/half/byte loads and stores, fixed LATENCY response pipeline, storage
// cleared by a counter sweep after reset.
// Optional macro DM_EXC_EN: enables misalign/range/illegal-op checking with
// resp_exc reporting; when undefined resp_exc is 0, addresses wrap modulo
// DEPTH_WORDS and low address bits are ignored for half/word accesses.
module dm_pipe
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_op,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  dm_state_e        state;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [LATENCY-1:0] pv;
  logic [31:0]        pd [LATENCY];
  logic [1:0]         pe [LATENCY];

  logic [2:0]       width;
  logic             wr;
  logic             accept;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [3:0]       st_mask;
  logic [31:0]      st_lanes;
  logic [31:0]      ld_data;
  logic             illegal;
  logic [1:0]       exc;
  logic             fault;

  assign width   = req_op[3:1];
  assign wr      = req_op[0];
  assign accept  = req_valid && req_ready;
  assign off     = req_addr - BASE_ADDR;
  assign idx     = IDX_W'(off >> 2);
  assign rword   = mem[idx];
  assign illegal = is_illegal(width, wr);

  dm_lane_fmt u_lane_fmt (
    .width    (width),
    .lane     (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (rword),
    .st_mask  (st_mask),
    .st_lanes (st_lanes),
    .ld_data  (ld_data)
  );

`ifdef DM_EXC_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  logic [32:0] diff;
  logic        misalign;
  logic        out_of_range;

  assign diff = {1'b0, req_addr} - {1'b0, BASE_ADDR};

  // Access checks, highest priority first: illegal, misaligned, out of range
  always_comb begin
    misalign = (((width == W_HALF) || (width == W_HALFU)) && req_addr[0]) ||
               ((width == W_WORD) && (req_addr[1:0] != 2'b00));
    out_of_range = diff[32] || ({1'b0, diff[31:0]} >= SPAN);
    if (illegal)           exc = EXC_ILLEGAL;
    else if (misalign)     exc = EXC_MISALIGN;
    else if (out_of_range) exc = EXC_RANGE;
    else                   exc = EXC_NONE;
  end

  assign fault = (exc != EXC_NONE);
`else
  assign exc   = EXC_NONE;
  assign fault = illegal;
`endif

  // Storage writes: zero sweep while clearing, lane-masked stores on accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (accept && wr && !fault) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (st_mask[i]) mem[idx][8*i +: 8] <= st_lanes[8*i +: 8];
        end
      end
    end
  end

  // Clear/run FSM and response pipeline; idle stages carry zero data
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clr_idx   <= '0;
      req_ready <= 1'b0;
      pv        <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pd[i] <= '0;
        pe[i] <= EXC_NONE;
      end
    end else begin
      if (state == ST_CLEAR) begin
        clr_idx <= clr_idx + IDX_W'(1);
        if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
          state     <= ST_RUN;
          req_ready <= 1'b1;
        end
      end else begin
        req_ready <= 1'b1;
      end
      pv[0] <= accept;
      pd[0] <= (accept && !wr && !fault) ? ld_data : '0;
      pe[0] <= accept ? exc : EXC_NONE;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  assign resp_valid = pv[LATENCY-1];
  assign resp_rdata = pd[LATENCY-1];
  assign resp_exc   = pe[LATENCY-1];
  assign busy       = (state != ST_RUN) || (|pv);

endmodule
